// File: rtl/alu_cmp_pipe.sv
// Two-stage valid/ready compare pipeline: S1 registers subtract flags, S2 the selected bit.
// Optional macro ALU_CMP_UNSIGNED_EN turns op 011 into unsigned less-than (LTU).
module alu_cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_NEQ = 3'b000;
  localparam logic [2:0] OP_EQ  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b010;
  localparam logic [2:0] OP_LTU = 3'b011;
  localparam logic [2:0] OP_LTZ = 3'b101;
  localparam logic [2:0] OP_LEZ = 3'b110;
  localparam logic [2:0] OP_GTZ = 3'b111;

  logic             vld_p1, vld_p2;
  logic             adv_p1, adv_p2;
  logic             z_p1, n_p1, v_p1, neg_p1, zero_p1, ltu_p1;
  logic [2:0]       op_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             res_p2;
  logic [TAG_W-1:0] tag_p2;

  logic signed [WIDTH-1:0] a_s, b_s, diff;
  logic                    ovf;

  function automatic logic sel_bit(input logic [2:0] op, input logic z, input logic n,
                                   input logic v, input logic neg, input logic zero,
                                   input logic ltu);
    sel_bit = 1'b0;
    case (op)
      OP_EQ:   sel_bit = z;
      OP_NEQ:  sel_bit = ~z;
      OP_LT:   sel_bit = n ^ v;
      OP_LTU:  sel_bit = ltu;
      OP_LEZ:  sel_bit = neg | zero;
      OP_LTZ:  sel_bit = neg;
      OP_GTZ:  sel_bit = ~neg & ~zero;
      default: sel_bit = 1'b0;
    endcase
  endfunction

  assign a_s  = in_a;
  assign b_s  = in_b;
  assign diff = a_s - b_s;
  // Signed overflow: operands differ in sign and the difference took B's sign.
  assign ovf  = (a_s[WIDTH-1] ^ b_s[WIDTH-1]) & (diff[WIDTH-1] ^ a_s[WIDTH-1]);

  assign adv_p2   = ~vld_p2 | out_ready;
  assign adv_p1   = ~vld_p1 | adv_p2;
  assign in_ready = adv_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: flags, op, tag ----
  always_ff @(posedge clk) begin
    if (in_valid && adv_p1) begin
      z_p1    <= (in_a == in_b);
      n_p1    <= diff[WIDTH-1];
      v_p1    <= ovf;
      neg_p1  <= in_a[WIDTH-1];
      zero_p1 <= (in_a == '0);
      op_p1   <= in_op;
      tag_p1  <= in_tag;
    end
  end

`ifdef ALU_CMP_UNSIGNED_EN
  logic [WIDTH:0] wide_diff;
  assign wide_diff = {1'b0, in_a} - {1'b0, in_b};

  always_ff @(posedge clk) begin
    if (in_valid && adv_p1) ltu_p1 <= wide_diff[WIDTH];
  end
`else
  assign ltu_p1 = 1'b0;
`endif

  // ---- stage 2: selected result bit ----
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_p2 <= '0;
    end else if (vld_p1 && adv_p2) begin
      res_p2 <= sel_bit(op_p1, z_p1, n_p1, v_p1, neg_p1, zero_p1, ltu_p1);
      tag_p2 <= tag_p1;
    end
  end

  // The bit is gated by valid so a stale register never shows through when idle.
  assign out_valid  = vld_p2;
  assign out_result = {{(WIDTH-1){1'b0}}, res_p2 & vld_p2};
  assign out_tag    = tag_p2;

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Directed plus random bench for alu_cmp_pipe with a queue-based reference model.
module tb_alu_cmp_pipe;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   nacc  = 0;

  alu_cmp_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic ref_bit(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      3'b001: return a == b;
      3'b000: return a != b;
      3'b010: return $signed(a) < $signed(b);
      3'b110: return $signed(a) <= 0;
      3'b101: return $signed(a) < 0;
      3'b111: return $signed(a) > 0;
`ifdef ALU_CMP_UNSIGNED_EN
      3'b011: return a < b;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_in(logic v, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                        logic [TW-1:0] tag);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag;
  endtask

  // One clock: sample handshakes mid-cycle, update the model, advance past the edge.
  task automatic step();
    logic ai, ao;
    exp_t e;
    #2;
    ai = in_valid && in_ready;
    ao = out_valid && out_ready;
    if (ao) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("result", out_result, e.res);
        chk("tag", out_tag, e.tag);
      end
    end
    if (!out_valid) chk("idle_zero", out_result, 0);
    if (reset || flush) exp_q.delete();
    else if (ai) begin
      e.res = {{(W-1){1'b0}}, ref_bit(in_op, in_a, in_b)};
      e.tag = in_tag;
      exp_q.push_back(e);
      nacc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(int n);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] za [3];
    logic [2:0]   zo [3];
    logic [W-1:0] hold_res;
    logic [TW-1:0] hold_tag;

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // latency of a single EQ
    set_in(1, 3'b001, 32'h0000_1234, 32'h0000_1234, 5'd7);
    step();
    chk("lat_n1_valid", out_valid, 0);
    set_in(0, 0, 0, 0, 0);
    step();
    chk("lat_n2_valid", out_valid, 1);
    chk("lat_n2_result", out_result, 32'h1);
    chk("lat_n2_tag", out_tag, 7);
    step();

    // back-to-back signed LT boundaries and NEQ
    set_in(1, 3'b010, 32'h8000_0000, 32'h0000_0001, 5'd1); step();
    set_in(1, 3'b010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd2); step();
    chk("b2b_first_res", out_result, 1);
    chk("b2b_first_tag", out_tag, 1);
    set_in(1, 3'b000, 32'd5, 32'd5, 5'd3); step();
    set_in(0, 0, 0, 0, 0);
    chk("b2b_v2", out_valid, 1);
    step();
    chk("b2b_v3", out_valid, 1);
    step();
    chk("b2b_done", out_valid, 0);

    // zero-compare ops with random B
    za = '{32'h0, 32'hFFFF_FFFF, 32'd7};
    zo = '{3'b110, 3'b101, 3'b111};
    for (int o = 0; o < 3; o++)
      for (int k = 0; k < 3; k++) begin
        set_in(1, zo[o], za[k], $urandom, TW'(o * 3 + k));
        step();
      end
    drain(4);

    // stall: consumer blocked for 5 cycles with input held valid
    out_ready = 1'b0; nacc = 0;
    hold_res = '0; hold_tag = '0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 3'($urandom_range(0, 7)), $urandom, $urandom, TW'($urandom));
      step();
      if (i == 1) begin hold_res = out_result; hold_tag = out_tag; end
      if (i >= 2) begin
        chk("stall_res_stable", out_result, hold_res);
        chk("stall_tag_stable", out_tag, hold_tag);
      end
    end
    chk("stall_accepts", nacc, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    drain(4);

    // flush with both stages full and a new input offered
    out_ready = 1'b0;
    set_in(1, 3'b001, 32'd1, 32'd1, 5'd10); step();
    set_in(1, 3'b000, 32'd1, 32'd2, 5'd11); step();
    set_in(1, 3'b001, 32'd3, 32'd3, 5'd12);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_result", out_result, 0);
    set_in(1, 3'b111, 32'd7, $urandom, 5'd9); step();
    chk("post_flush_n1", out_valid, 0);
    set_in(0, 0, 0, 0, 0); step();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_result", out_result, 1);
    chk("post_flush_tag", out_tag, 9);
    drain(2);

    // unsigned compare / reserved ops
    set_in(1, 3'b011, 32'd1, 32'hFFFF_FFFF, 5'd20); step();
    set_in(1, 3'b011, 32'hFFFF_FFFF, 32'd1, 5'd21); step();
    set_in(1, 3'b100, $urandom, $urandom, 5'd22); step();
    drain(4);

    // mid-stream reset drops everything in flight
    out_ready = 1'b0;
    set_in(1, 3'b001, 32'd4, 32'd4, 5'd1); step();
    set_in(1, 3'b001, 32'd4, 32'd4, 5'd2); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_tag", out_tag, 0);
    drain(3);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a;
      a = $urandom;
      set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             ($urandom_range(0, 3) == 0) ? a : W'($urandom), TW'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
